calc_btn_cond: RTL
==================

CALC_BTN_COND -- requirements
Module: calc_btn_cond

Interface
REQ-001 SHALL have parameter: DEBOUNCE_CYCLES, 500000, consecutive stable samples required to accept a level change (5 ms at 100 MHz); legal range >= 2.
REQ-002 SHALL have port: clk  input  1  system clock, all state updates on rising edge.
REQ-003 SHALL have port: resetn  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: btn_raw  input  5  asynchronous push-buttons; bit order [4:0] = btnd, btnr, btnl, btnu, btnc.
REQ-005 SHALL have port: btn_level  output  5  debounced button levels, same bit order; bits [3:1] drive the downstream opcode decoder directly.
REQ-006 SHALL have port: btn_press  output  5  one-cycle pulse on each debounced rising edge.
REQ-007 SHALL have port: btn_release  output  5  one-cycle pulse on each debounced falling edge.
REQ-008 SHALL use one clock, clk; reset SHALL be synchronous and active-low on resetn.

Function
REQ-009 SHALL condition all five channels independently and identically; one channel's activity SHALL never affect another's timing.
REQ-010 SHALL pass each raw bit through SYNC_STAGES flops (see Configuration) before use; the last flop's output is the sample s.
REQ-011 Per-channel FSM SHALL have states: IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO.
REQ-012 IDLE_LO: s=1 -> WAIT_HI with counter=1; else stay, counter=0.
REQ-013 WAIT_HI: s=0 -> IDLE_LO, counter=0 (bounce rejected); s=1 and counter=DEBOUNCE_CYCLES-1 -> IDLE_HI, counter=0; else counter+1.
REQ-014 IDLE_HI/WAIT_LO SHALL mirror REQ-012/013 with s polarity inverted.
REQ-015 btn_level SHALL be registered: 1 in IDLE_HI and WAIT_LO, 0 in IDLE_LO and WAIT_HI.
REQ-016 btn_press SHALL be 1 for exactly the cycle after the WAIT_HI->IDLE_HI edge, aligned with btn_level first reading 1; btn_release likewise for WAIT_LO->IDLE_LO.
REQ-017 For raw input held constant, btn_level SHALL change exactly SYNC_STAGES+DEBOUNCE_CYCLES rising edges after the first edge sampling the new raw value.
REQ-018 Any pulse on s shorter than DEBOUNCE_CYCLES cycles SHALL produce no output change and no pulse.
REQ-019 Counter width SHALL be $clog2(DEBOUNCE_CYCLES)+1 bits; the counter SHALL never wrap; it never exceeds DEBOUNCE_CYCLES-1.
REQ-020 btn_press and btn_release SHALL never be 1 simultaneously on the same bit; at most one pulse per bit per DEBOUNCE_CYCLES cycles.

Reset
REQ-021 When resetn=0 at a rising edge: all synchronizer flops, counters, btn_level, btn_press, and btn_release SHALL be 0 and every FSM SHALL be in IDLE_LO from the next cycle.
REQ-022 Reset SHALL abort any in-progress count with no pulse emitted; a button held through reset release SHALL be accepted as a fresh press after REQ-017 latency.

Configuration
REQ-023 With CALC_BTN_SYNC2_EN defined, SYNC_STAGES SHALL be 2 (two-flop metastability synchronizer).
REQ-024 Without CALC_BTN_SYNC2_EN, SYNC_STAGES SHALL be 1 (single input register); all other behaviour is unchanged.

Structure
REQ-025 The package calc_pkg SHALL hold the button index constants (BTN_C=0, BTN_U=1, BTN_L=2, BTN_R=3, BTN_D=4) and the debounce state typedef.
REQ-026 The single-channel synchronizer + FSM + counter SHALL be a sub-module, calc_debounce, instantiated five times by calc_btn_cond.

Verification (DEBOUNCE_CYCLES=4, CALC_BTN_SYNC2_EN defined unless noted)
REQ-027 Clean press: btn_raw[2] 0->1 sampled at edge 10, held -> btn_level[2]=1 from edge 16; btn_press[2]=1 for that single cycle only.
REQ-028 Bounce: btn_raw[2] high edges 10-12, low edge 13, high from 14 held -> no pulse before edge 20; btn_level[2] rises at edge 20.
REQ-029 Release: after REQ-027, btn_raw[2] low from edge 30 -> btn_level[2]=0 at edge 36; btn_release[2] pulses once; btn_press stays 0.
REQ-030 Chord: btn_raw[2] and btn_raw[4] rise on same edge -> both btn_level bits rise on same edge, both press pulses coincide; other bits stay 0.
REQ-031 Reset mid-count: resetn=0 at edge 13 during WAIT_HI, released at 14, raw held high -> all outputs 0 at 14; btn_level[2] rises at edge 20.
REQ-032 Macro undefined: repeat REQ-027 -> btn_level[2] rises at edge 15.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator push-button conditioner.
//
// Contents:
//   BTN_C/BTN_U/BTN_L/BTN_R/BTN_D : bit positions of each button in the
//                                   5-bit button buses.
//   NUM_BTNS                      : number of button channels.
//   deb_state_e                   : per-channel debounce state.
//   SYNC_STAGES                   : input synchronizer depth.
//
// Build option:
//   CALC_BTN_SYNC2_EN defined   -> SYNC_STAGES = 2 (metastability synchronizer)
//   CALC_BTN_SYNC2_EN undefined -> SYNC_STAGES = 1 (single input register)
package calc_pkg;

    localparam int unsigned BTN_C    = 0;
    localparam int unsigned BTN_U    = 1;
    localparam int unsigned BTN_L    = 2;
    localparam int unsigned BTN_R    = 3;
    localparam int unsigned BTN_D    = 4;
    localparam int unsigned NUM_BTNS = 5;

    typedef enum logic [1:0] {
        IDLE_LO,
        WAIT_HI,
        IDLE_HI,
        WAIT_LO
    } deb_state_e;

`ifdef CALC_BTN_SYNC2_EN
    localparam int unsigned SYNC_STAGES = 2;
`else
    localparam int unsigned SYNC_STAGES = 1;
`endif

endpackage

// File: rtl/calc_debounce.sv
// Single-channel button conditioner: input synchronizer, debounce FSM with
// stability counter, and registered level/press/release outputs.
//
// Ports:
//   clk    : system clock, rising edge
//   resetn : synchronous active-low reset
//   raw    : asynchronous button input
//   level  : debounced level (registered)
//   press  : one-cycle pulse when level first reads 1
//   rls    : one-cycle pulse when level first reads 0
//
// Synchronizer depth comes from calc_pkg::SYNC_STAGES (CALC_BTN_SYNC2_EN).
module calc_debounce
    import calc_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic resetn,
    input  logic raw,
    output logic level,
    output logic press,
    output logic rls
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    deb_state_e             state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   press_q, press_d;
    logic                   rls_q, rls_d;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d    = sync_q << 1;
        sync_d[0] = raw;
    end

    // The counter tracks how many consecutive samples have disagreed with
    // the accepted level; it is cleared whenever the FSM is not waiting.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        unique case (state_q)
            IDLE_LO: begin
                if (s) begin
                    state_d = WAIT_HI;
                    cnt_d   = CNT_ONE;
                end
            end
            WAIT_HI: begin
                if (!s) begin
                    state_d = IDLE_LO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE_HI;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            IDLE_HI: begin
                if (!s) begin
                    state_d = WAIT_LO;
                    cnt_d   = CNT_ONE;
                end
            end
            WAIT_LO: begin
                if (s) begin
                    state_d = IDLE_HI;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE_LO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
        endcase
    end

    // Level is decoded from the current state and registered, so the edge
    // pulses compare the new level against the registered one to stay
    // aligned with the first cycle the level output changes.
    always_comb begin
        level_d = (state_q == IDLE_HI) || (state_q == WAIT_LO);
        press_d = level_d & ~level_q;
        rls_d   = ~level_d & level_q;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync_q  <= '0;
            state_q <= IDLE_LO;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rls_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
            rls_q   <= rls_d;
        end
    end

    assign level = level_q;
    assign press = press_q;
    assign rls   = rls_q;

endmodule

// File: rtl/calc_btn_cond.sv
// Calculator push-button conditioner: five independent debounce channels.
//
// Ports:
//   clk         : system clock, rising edge
//   resetn      : synchronous active-low reset
//   btn_raw     : raw buttons, [4:0] = btnd, btnr, btnl, btnu, btnc
//   btn_level   : debounced levels, same order ([3:1] feed the opcode decoder)
//   btn_press   : one-cycle pulse per debounced rising edge
//   btn_release : one-cycle pulse per debounced falling edge
//
// Build option: CALC_BTN_SYNC2_EN selects a two-flop input synchronizer.
module calc_btn_cond
    import calc_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [4:0] btn_raw,
    output logic [4:0] btn_level,
    output logic [4:0] btn_press,
    output logic [4:0] btn_release
);

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_chan
        calc_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk   (clk),
            .resetn(resetn),
            .raw   (btn_raw[i]),
            .level (btn_level[i]),
            .press (btn_press[i]),
            .rls   (btn_release[i])
        );
    end

endmodule
